// File: rtl/regfile_pkg.sv
// Shared types and sizing for the operand-fetch slice.
// Provides the address-width helper, default register-file geometry and
// the request/operand payload structs used by operand_fetch.
package regfile_pkg;

   // Register address width for a given register count (at least 1 bit).
   function automatic int unsigned addr_width(input int unsigned n_regs);
      return (n_regs > 1) ? $clog2(n_regs) : 1;
   endfunction

   localparam int unsigned RF_N_REGS     = 32;
   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_ADDR_WIDTH = addr_width(RF_N_REGS);

   // Instruction as accepted from decode.
   typedef struct packed {
      logic [RF_ADDR_WIDTH-1:0] src0;
      logic [RF_ADDR_WIDTH-1:0] src1;
      logic [RF_ADDR_WIDTH-1:0] dst;
      logic                     dst_we;
   } fetch_req_t;

   // Operands plus destination as presented to execute.
   typedef struct packed {
      logic [RF_DATA_WIDTH-1:0] op0;
      logic [RF_DATA_WIDTH-1:0] op1;
      logic [RF_ADDR_WIDTH-1:0] dst;
      logic                     dst_we;
   } operand_bundle_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register.
// Ports: clk/rst; set_i/set_addr_i marks a register busy on issue;
// clr_i/clr_addr_i clears it on writeback (set wins on collision);
// src0/src1/dst query ports return the current busy bit combinationally.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int unsigned N_REGS     = RF_N_REGS,
   localparam int unsigned ADDR_WIDTH = addr_width(N_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_i,
   input  logic [ADDR_WIDTH-1:0] set_addr_i,
   input  logic                  clr_i,
   input  logic [ADDR_WIDTH-1:0] clr_addr_i,
   input  logic [ADDR_WIDTH-1:0] src0_addr_i,
   input  logic [ADDR_WIDTH-1:0] src1_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   output logic                  src0_busy_c_o,
   output logic                  src1_busy_c_o,
   output logic                  dst_busy_c_o
);

   logic [N_REGS-1:0] busy_q, busy_d;

   // Clear applied first so a same-cycle set on the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_addr_i] = 1'b0;
      if (set_i) busy_d[set_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign src0_busy_c_o = busy_q[src0_addr_i];
   assign src1_busy_c_o = busy_q[src1_addr_i];
   assign dst_busy_c_o  = busy_q[dst_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage between decode and execute.
// Ports: in_* decode handshake (two sources, destination, write flag);
// out_* operands to execute over valid/ready; wb_* writeback from commit,
// passed straight to the register-file write port; rf_* two registered read
// ports plus write port. S1 holds the accepted request, S2 the issued one
// whose read data returns on rf_rdata; a writeback landing in the issue
// cycle is captured and substituted for the stale register-file value.
module operand_fetch
   import regfile_pkg::*;
#(
   parameter  int unsigned N_REGS     = RF_N_REGS,
   parameter  int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   localparam int unsigned ADDR_WIDTH = addr_width(N_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_WIDTH-1:0]      in_src0,
   input  logic [ADDR_WIDTH-1:0]      in_src1,
   input  logic [ADDR_WIDTH-1:0]      in_dst,
   input  logic                       in_dst_we,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_op0,
   output logic [DATA_WIDTH-1:0]      out_op1,
   output logic [ADDR_WIDTH-1:0]      out_dst,
   output logic                       out_dst_we,
   input  logic                       wb_valid,
   input  logic [ADDR_WIDTH-1:0]      wb_addr,
   input  logic [DATA_WIDTH-1:0]      wb_data,
   output logic                       rf_en,
   output logic [1:0]                 rf_re,
   output logic [1:0][ADDR_WIDTH-1:0] rf_raddr,
   input  logic [1:0][DATA_WIDTH-1:0] rf_rdata,
   output logic                       rf_we,
   output logic [ADDR_WIDTH-1:0]      rf_waddr,
   output logic [DATA_WIDTH-1:0]      rf_wdata
);

   fetch_req_t            s1_q, s1_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [ADDR_WIDTH-1:0] s2_dst_q, s2_dst_d;
   logic                  s2_dst_we_q, s2_dst_we_d;
   logic [DATA_WIDTH-1:0] fwd0_q, fwd0_d, fwd1_q, fwd1_d;
   logic [1:0]            fwd_sel_q, fwd_sel_d;

   logic src0_busy_c, src1_busy_c, dst_busy_c;
   logic wb_hit0_c, wb_hit1_c, hazard_c, issue_c, accept_c;

   rf_scoreboard #(.N_REGS(N_REGS)) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .set_i        (issue_c && s1_q.dst_we),
      .set_addr_i   (s1_q.dst),
      .clr_i        (wb_valid),
      .clr_addr_i   (wb_addr),
      .src0_addr_i  (s1_q.src0),
      .src1_addr_i  (s1_q.src1),
      .dst_addr_i   (s1_q.dst),
      .src0_busy_c_o(src0_busy_c),
      .src1_busy_c_o(src1_busy_c),
      .dst_busy_c_o (dst_busy_c)
   );

   // A busy source is satisfied by a writeback in the same cycle; WAW is not.
   assign wb_hit0_c = wb_valid && (wb_addr == s1_q.src0);
   assign wb_hit1_c = wb_valid && (wb_addr == s1_q.src1);
   assign hazard_c  = (src0_busy_c && !wb_hit0_c) || (src1_busy_c && !wb_hit1_c) ||
                      (s1_q.dst_we && dst_busy_c);
   assign issue_c   = s1_valid_q && !hazard_c && (!s2_valid_q || out_ready);
   assign in_ready  = !s1_valid_q || issue_c;
   assign accept_c  = in_valid && in_ready;

   // Pipeline slot next-state.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      s2_valid_d  = s2_valid_q;
      s2_dst_d    = s2_dst_q;
      s2_dst_we_d = s2_dst_we_q;
      fwd0_d      = fwd0_q;
      fwd1_d      = fwd1_q;
      fwd_sel_d   = fwd_sel_q;

      if (issue_c) s1_valid_d = 1'b0;
      if (accept_c) begin
         s1_valid_d  = 1'b1;
         s1_d.src0   = in_src0;
         s1_d.src1   = in_src1;
         s1_d.dst    = in_dst;
         s1_d.dst_we = in_dst_we;
      end

      if (issue_c) begin
         s2_valid_d  = 1'b1;
         s2_dst_d    = s1_q.dst;
         s2_dst_we_d = s1_q.dst_we;
         fwd0_d      = wb_data;
         fwd1_d      = wb_data;
         fwd_sel_d   = {wb_hit1_c, wb_hit0_c};
      end else if (out_ready) begin
         s2_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s2_valid_q  <= 1'b0;
         s2_dst_q    <= '0;
         s2_dst_we_q <= 1'b0;
         fwd0_q      <= '0;
         fwd1_q      <= '0;
         fwd_sel_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s2_valid_q  <= s2_valid_d;
         s2_dst_q    <= s2_dst_d;
         s2_dst_we_q <= s2_dst_we_d;
         fwd0_q      <= fwd0_d;
         fwd1_q      <= fwd1_d;
         fwd_sel_q   <= fwd_sel_d;
      end
   end

   // Reads go out only on issue, so rf_rdata holds while S2 is stalled.
   assign rf_en       = 1'b1;
   assign rf_re       = {issue_c, issue_c};
   assign rf_raddr[0] = s1_q.src0;
   assign rf_raddr[1] = s1_q.src1;

   assign out_valid  = s2_valid_q;
   assign out_op0    = !s2_valid_q ? '0 : (fwd_sel_q[0] ? fwd0_q : rf_rdata[0]);
   assign out_op1    = !s2_valid_q ? '0 : (fwd_sel_q[1] ? fwd1_q : rf_rdata[1]);
   assign out_dst    = s2_dst_q;
   assign out_dst_we = s2_dst_we_q;

   assign rf_we    = wb_valid;
   assign rf_waddr = wb_addr;
   assign rf_wdata = wb_data;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file, program-order value
// model, scoreboard queue of expected operand bundles, writeback engine.
module tb_operand_fetch;
   import regfile_pkg::*;

   localparam int unsigned AW = RF_ADDR_WIDTH;
   localparam int unsigned DW = RF_DATA_WIDTH;
   localparam int unsigned NR = RF_N_REGS;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, in_dst_we;
   logic [AW-1:0] in_src0, in_src1, in_dst;
   logic out_valid, out_ready, out_dst_we;
   logic [DW-1:0] out_op0, out_op1;
   logic [AW-1:0] out_dst;
   logic wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic rf_en, rf_we;
   logic [1:0] rf_re;
   logic [1:0][AW-1:0] rf_raddr;
   logic [1:0][DW-1:0] rf_rdata;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   operand_fetch dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_src0(in_src0), .in_src1(in_src1),
      .in_dst(in_dst), .in_dst_we(in_dst_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
      .out_dst(out_dst), .out_dst_we(out_dst_we),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_en(rf_en), .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register file: registered reads return the pre-write value; reset loads r[i] = 10*i.
   logic [DW-1:0] rf_mem [NR];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < int'(NR); i++) rf_mem[i] <= DW'(i * 10);
      else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
      for (int k = 0; k < 2; k++) if (rf_re[k]) rf_rdata[k] <= rf_mem[rf_raddr[k]];
   end

   // Program-order architectural state and scoreboard queues.
   logic [DW-1:0] arch [NR];
   operand_bundle_t exp_q[$];
   logic [DW-1:0] res_q[$];

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_ent_t;
   wb_ent_t wb_l[$];
   int wb_dmin = 1;
   int wb_dmax = 5;

   task automatic arch_reset();
      for (int i = 0; i < int'(NR); i++) arch[i] = DW'(i * 10);
   endtask

   // Writeback engine: at most one due entry per cycle.
   initial begin
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      forever begin
         @(posedge clk); #2;
         wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
         for (int i = 0; i < wb_l.size(); i++) begin
            if (wb_l[i].due <= cyc) begin
               wb_valid = 1'b1; wb_addr = wb_l[i].addr; wb_data = wb_l[i].data;
               wb_l.delete(i);
               break;
            end
         end
      end
   end

   // Execute-side ready: random or forced (mode changes only at negedge).
   logic rnd_rdy = 1'b0;
   logic force_rdy = 1'b1;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
      end
   end

   // Monitor: compare presented bundle against the queue head; pop on handshake.
   always @(negedge clk) begin
      operand_bundle_t e;
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out: got op0=%0h op1=%0h with empty queue", out_op0, out_op1);
         end else begin
            e = exp_q[0];
            chk(out_ready ? "out_op0" : "hold_op0", 64'(out_op0), 64'(e.op0));
            chk(out_ready ? "out_op1" : "hold_op1", 64'(out_op1), 64'(e.op1));
            chk(out_ready ? "out_dst" : "hold_dst", 64'({out_dst, out_dst_we}), 64'({e.dst, e.dst_we}));
            if (out_ready) begin
               void'(exp_q.pop_front());
               if (e.dst_we) begin
                  logic [DW-1:0] r;
                  r = res_q.pop_front();
                  wb_l.push_back('{cyc + $urandom_range(wb_dmin, wb_dmax), e.dst, r});
               end
            end
         end
      end
   end

   // Offer one instruction; expected operands come from program-order state.
   task automatic send(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [AW-1:0] d,
                       input logic we, input logic [DW-1:0] res, output int waits);
      operand_bundle_t e;
      logic acc = 1'b0;
      waits = 0;
      in_valid = 1'b1; in_src0 = s0; in_src1 = s1; in_dst = d; in_dst_we = we;
      while (!acc && waits <= 300) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            e.op0 = arch[s0]; e.op1 = arch[s1]; e.dst = d; e.dst_we = we;
            exp_q.push_back(e);
            if (we) begin arch[d] = res; res_q.push_back(res); end
         end else waits++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL send_timeout: src0=%0d src1=%0d not accepted", s0, s1);
      end
   endtask

   task automatic set_rdy(input logic rnd, input logic frc);
      @(negedge clk); rnd_rdy = rnd; force_rdy = frc;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || wb_l.size() != 0) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_wb_empty", 64'(wb_l.size()), 64'd0);
      repeat (2) @(posedge clk); #1;
   endtask

   // Wait for the writeback of addr; the stalled reader must issue that cycle.
   task automatic wait_wb_issue(input logic [AW-1:0] addr, input string name);
      logic found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (wb_valid && wb_addr == addr) begin
            found = 1'b1;
            chk({name, "_issue_re"}, 64'(rf_re), 64'd3);
            chk({name, "_issue_raddr0"}, 64'(rf_raddr[0]), 64'(addr));
            @(negedge clk);
            chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
         end
      end
      chk({name, "_wb_seen"}, 64'(found), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int w1, w2, wd;
      rst = 1'b1; in_valid = 1'b0; in_src0 = '0; in_src1 = '0; in_dst = '0; in_dst_we = 1'b0;
      arch_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_rf_re", 64'(rf_re), 64'd0);
      chk("rst_out_op", 64'({out_op0, out_op1}), 64'd0);
      chk("rst_out_dst", 64'({out_dst, out_dst_we}), 64'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rf_en", 64'(rf_en), 64'd1);
      @(posedge clk); #1;

      // Independent stream: back-to-back, two-cycle latency.
      send(AW'(1), AW'(2), AW'(20), 1'b0, '0, w1);
      send(AW'(3), AW'(4), AW'(21), 1'b0, '0, w2);
      chk("indep_no_stall", 64'(w1 + w2), 64'd0);
      @(negedge clk);
      chk("indep_latency", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      drain();

      // RAW stall resolved by forwarding from the writeback.
      wb_dmin = 4; wb_dmax = 4;
      send(AW'(1), AW'(2), AW'(5), 1'b1, DW'(32'hAB), wd);
      send(AW'(5), AW'(6), AW'(12), 1'b0, '0, wd);
      wait_wb_issue(AW'(5), "raw");
      drain();

      // Both sources forwarded from one writeback.
      send(AW'(3), AW'(4), AW'(7), 1'b1, DW'(32'h1234), wd);
      send(AW'(7), AW'(7), AW'(15), 1'b0, '0, wd);
      wait_wb_issue(AW'(7), "dfwd");
      drain();

      // Back-pressure: three requests behind a stalled execute.
      wb_dmin = 1; wb_dmax = 3;
      set_rdy(1'b0, 1'b0);
      fork
         begin
            send(AW'(1), AW'(2), AW'(16), 1'b1, DW'(32'h111), wd);
            send(AW'(3), AW'(16), AW'(17), 1'b1, DW'(32'h222), wd);
            send(AW'(17), AW'(4), AW'(18), 1'b0, '0, wd);
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            force_rdy = 1'b1;
         end
      join
      drain();

      // Set/clear collision on register 9.
      wb_dmin = 6; wb_dmax = 6;
      send(AW'(1), AW'(2), AW'(9), 1'b1, DW'(32'h9999), wd);
      wb_l.push_back('{cyc, AW'(9), DW'(32'hDEAD)});
      @(negedge clk);
      chk("coll_issue_re", 64'(rf_re), 64'd3);
      chk("coll_wb", 64'({wb_valid, wb_addr}), 64'({1'b1, AW'(9)}));
      @(posedge clk); #1;
      send(AW'(9), AW'(3), AW'(19), 1'b0, '0, wd);
      @(negedge clk);
      chk("coll_reader_stalls", 64'(rf_re[0]), 64'd0);
      @(posedge clk); #1;
      drain();

      // Reset while a reader of register 5 is stalled in S1.
      wb_dmin = 60; wb_dmax = 60;
      send(AW'(1), AW'(2), AW'(5), 1'b1, DW'(32'h5555), wd);
      send(AW'(5), AW'(6), AW'(13), 1'b0, '0, wd);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rs_stalled", 64'(rf_re), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete(); res_q.delete(); wb_l.delete();
      arch_reset();
      @(negedge clk);
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rs_in_ready", 64'(in_ready), 64'd1);
      chk("rs_out_valid_after", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      wb_dmin = 1; wb_dmax = 5;
      send(AW'(5), AW'(5), AW'(14), 1'b0, '0, wd);
      @(negedge clk);
      chk("rs_no_stall_re", 64'(rf_re), 64'd3);
      chk("rs_no_stall_raddr", 64'(rf_raddr[0]), 64'd5);
      @(posedge clk); #1;
      drain();

      // Randomised traffic over a small register window to provoke hazards.
      set_rdy(1'b1, 1'b1);
      for (int n = 0; n < 300; n++) begin
         send(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), DW'($urandom), wd);
      end
      set_rdy(1'b0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
